// File: rtl/reg_write_arbiter.sv
// Round-robin req/gnt/ack arbiter sharing one enable-gated register among NUM_REQ writers.
// Optional REG_WRITE_ARB_LOCK_EN adds per-requester lock for back-to-back writes.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef REG_WRITE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [DATA_W-1:0]         q,
  output logic [ID_W-1:0]           owner
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] sel, sel_nxt;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            wr_en;
  int              idx;

  // Search starts just after the last committed writer, wrapping around.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last) + i) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    wr_en     = 1'b0;
    gnt       = '0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt[sel] = 1'b1;
        // A requester that drops req before commit aborts without writing.
        if (req[sel]) begin
          wr_en     = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK: begin
        ack[sel]  = 1'b1;
        state_nxt = IDLE;
`ifdef REG_WRITE_ARB_LOCK_EN
        if (lock[sel] && req[sel]) state_nxt = GRANT;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel   <= '0;
      last  <= ID_W'(NUM_REQ - 1);
      q     <= '0;
      owner <= '0;
    end else begin
      sel <= sel_nxt;
      if (wr_en) begin
        q     <= wdata[sel*DATA_W +: DATA_W];
        owner <= sel;
        last  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected writes queued at stimulus, checked on ack.
module tb_reg_write_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] wdata = '0;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        lock = '0;
`endif
  logic [NUM_REQ-1:0]        gnt, ack;
  logic                      busy;
  logic [DATA_W-1:0]         q;
  logic [ID_W-1:0]           owner;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int exp_id[$];
  logic [DATA_W-1:0] exp_dat[$];

  reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
`ifdef REG_WRITE_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .busy(busy), .q(q), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [DATA_W-1:0] d);
    exp_id.push_back(id);
    exp_dat.push_back(d);
  endtask

  // Every ack must match the oldest queued write.
  always @(negedge clk) begin
    if (!reset && ack != '0) begin
      if (exp_id.size() == 0) begin
        check("ack_unexpected", 32'(ack), 32'h0);
      end else begin
        int id;
        logic [DATA_W-1:0] d;
        id = exp_id.pop_front();
        d  = exp_dat.pop_front();
        check("sb_ack", 32'(ack), 32'(1 << id));
        check("sb_q", 32'(q), 32'(d));
        check("sb_owner", 32'(owner), 32'(id));
      end
    end
  end

  task automatic run_until_idle(input int budget);
    int n = 0;
    int prev = -1;
    while ((req != '0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin
        if (prev >= 0) check("ack_spacing", 32'(cyc - prev), 32'd3);
        prev = cyc;
        req = req & ~ack;
      end
    end
    if (n >= budget) check("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", 32'({gnt, ack, busy}), 32'd0);
    end
    check("idle_q", 32'(q), 32'h00);
    check("idle_owner", 32'(owner), 32'd0);

    // Contention from reset: order 0,1,2,3
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);
      push(i, 8'h10 + 8'(i));
    end
    req = 4'b1111;
    run_until_idle(60);

    // Single writer
    wdata[2*DATA_W +: DATA_W] = 8'hA5;
    push(2, 8'hA5);
    req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'b0100);
    check("single_noack", 32'(ack), 32'd0);
    @(negedge clk);
    check("single_ack", 32'(ack), 32'b0100);
    check("single_gnt_off", 32'(gnt), 32'd0);
    req = '0;
    @(negedge clk);
    check("single_idle", 32'(busy), 32'd0);

    // Abort: req[1] for one cycle
    wdata[1*DATA_W +: DATA_W] = 8'hEE;
    req = 4'b0010;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'b0010);
    req = '0;
    @(negedge clk);
    check("abort_outs", 32'({gnt, ack, busy}), 32'd0);
    check("abort_q", 32'(q), 32'hA5);
    check("abort_owner", 32'(owner), 32'd2);
    @(negedge clk);
    // last still 2, so requester 1 beats requester 2
    wdata[1*DATA_W +: DATA_W] = 8'h31;
    wdata[2*DATA_W +: DATA_W] = 8'h42;
    push(1, 8'h31);
    push(2, 8'h42);
    req = 4'b0110;
    run_until_idle(40);

    // Async reset during gnt[3]
    wdata[3*DATA_W +: DATA_W] = 8'h77;
    req = 4'b1000;
    @(negedge clk);
    check("rstmid_gnt", 32'(gnt), 32'b1000);
    #2 reset = 1'b1;
    #1;
    check("rstmid_outs", 32'({gnt, ack, busy}), 32'd0);
    check("rstmid_q", 32'(q), 32'h00);
    check("rstmid_owner", 32'(owner), 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_q_hold", 32'(q), 32'h00);
    wdata[0*DATA_W +: DATA_W] = 8'h0A;
    wdata[3*DATA_W +: DATA_W] = 8'h3B;
    push(0, 8'h0A);
    push(3, 8'h3B);
    req = 4'b1001;
    run_until_idle(40);

`ifdef REG_WRITE_ARB_LOCK_EN
    begin
      int k = 0;
      int prev = -1;
      int n = 0;
      wdata[1*DATA_W +: DATA_W] = 8'h51;
      wdata[0*DATA_W +: DATA_W] = 8'h60;
      push(1, 8'h51);
      push(1, 8'h52);
      push(1, 8'h53);
      push(0, 8'h60);
      lock = 4'b0010;
      req  = 4'b0010;
      @(negedge clk);
      check("lock_gnt", 32'(gnt), 32'b0010);
      req[0] = 1'b1;
      while ((req != '0 || busy) && n < 40) begin
        @(negedge clk);
        n++;
        if (lock[1]) check("lock_starve", 32'(gnt[0]), 32'd0);
        if (ack[1]) begin
          k++;
          if (prev >= 0) check("lock_spacing", 32'(cyc - prev), 32'd2);
          prev = cyc;
          if (k < 3) wdata[1*DATA_W +: DATA_W] = 8'h51 + 8'(k);
          else begin
            lock[1] = 1'b0;
            req[1]  = 1'b0;
          end
        end
        if (ack[0]) req[0] = 1'b0;
      end
      if (n >= 40) check("lock_timeout", 32'd1, 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_id.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one enable-gated storage register (DATA_W bits) among NUM_REQ requesters.
- Round-robin arbitration with a req/gnt/ack handshake. The selected requester's data is captured through an internal enable-gated flop.
- Sits between multiple config/control masters and a single shared control register. Exposes the stored value and the identity of its last writer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of each write word and of the stored register
- ID_W, $clog2(NUM_REQ), width of owner id

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester write request, level, held until ack
- wdata  input  NUM_REQ*DATA_W  write words, requester i at bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot grant, at most one bit set
- ack  output  NUM_REQ  one-hot, single-cycle pulse: write committed
- busy  output  1  high in any state other than IDLE
- q  output  DATA_W  stored register value
- owner  output  ID_W  index of requester that last wrote q

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset (asynchronous, immediate): state=IDLE; gnt=0, ack=0, busy=0, q=0, owner=0; round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If any req bit is set, pick winner w = first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch w and go to GRANT. Otherwise stay in IDLE.
- GRANT (one cycle):
  - gnt[w]=1.
  - If req[w] is still 1: internal register enable=1, so q<=wdata[w] and owner<=w at the closing edge; last<=w; next state ACK.
  - If req[w] has dropped: abort. No write, no ack, last unchanged, next state IDLE.
- ACK (one cycle):
  - ack[w]=1, gnt=0; q already shows the new value.
  - Next state IDLE, or GRANT under the lock feature.
- Timing:
  - Latency from req sampled in IDLE: gnt in cycle +1, ack and new q in cycle +2.
  - Throughput: one write per 3 cycles without lock.
- Requester rules: hold req and wdata stable from assertion until ack. The requester may deassert req in the cycle after ack. If req is still high when the FSM re-enters IDLE, that counts as a new request.
- wdata is sampled only in GRANT; changes in other cycles have no effect.
- Simultaneous requests: round-robin guarantees each active requester a grant within NUM_REQ arbitration rounds.
- Requests that arrive while busy are held off; they are evaluated at the next IDLE.
- q holds its value whenever the enable is 0 (all states except a committed GRANT).
- Reset mid-operation (GRANT or ACK): outputs clear immediately, the pending write is lost, q=0.
- Outputs gnt, ack and busy are decoded from registered state only; no combinational path from req.

Optional Feature:
- Macro: REG_WRITE_ARB_LOCK_EN.
- When defined:
  - Adds input lock [NUM_REQ].
  - In ACK, if lock[w]=1 and req[w]=1, the next state is GRANT for the same w with no arbitration, giving back-to-back writes every 2 cycles. Other requesters are starved while the lock is held.
  - Lock dropping causes a normal return to IDLE.
- When undefined: no lock port; ACK always goes to IDLE; strict round-robin.

Test Plan:
- Reset then idle: after reset, with req=0 for 10 cycles -> gnt=0, ack=0, busy=0, q=0x00, owner=0.
- Single writer: req[2]=1, wdata[2]=0xA5 -> gnt=4'b0100 at cycle +1, ack=4'b0100 and q=0xA5, owner=2 at cycle +2, then busy=0.
- Contention: req=4'b1111 held, each deasserting after its own ack, with wdata[i]=0x10+i -> grant order 0,1,2,3; q sequence 0x10, 0x11, 0x12, 0x13; each ack 3 cycles apart.
- Abort: req[1] pulsed for 1 cycle only -> gnt[1] for one cycle, no ack, q unchanged, next arbitration still starts at requester 1.
- Async reset mid-GRANT: assert reset during gnt[3] -> gnt, q and owner clear immediately; after release, requester 0 wins first.
- Lock (REG_WRITE_ARB_LOCK_EN): lock[1]=1, req=4'b0011 -> requester 1 acks every 2 cycles while locked; requester 0 granted only after lock[1] drops.
